arcade_input_mapper: RTL and testbench

Parametrised player-input conditioner between `hps_io` joystick words and the game core's active-low `PLAYERn` buses. Generalises the fixed two-player combinational mapping to NPLAYERS × NBTN. Adds the following, all synchronous to the core clock:
- coin pulse stretching
- SOCD (opposing-direction) resolution
- per-button autofire paced by VBLANK
- a latched pause toggle

---
 rtl/arcade_input_mapper.sv | 227 ++++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: MiSTer joystick words -> active-low PLAYERn buses with coin stretch,
//   SOCD resolution, VBLANK-paced autofire and a latched pause toggle.
// Latency: 2 i_clk cycles from joystick/vblank to o_player/o_pause. No backpressure: free-running sampled path.
// Optional feature macro: INPUT_AUTOFIRE_EN (frame counter, tick and per-button phase; af_mask honoured).
// Ports: i_clk core clock; RESETn async active-low reset; joystick 16 bits/player active-high
//   (R,L,D,U, buttons, start, coin, service, pause); vblank frame blank; af_mask per-button autofire
//   enable; socd_mode opposing-direction policy; o_player 16 bits/player active-low; o_pause pause level.
module arcade_input_mapper #(
    parameter int          NPLAYERS  = 2,
    parameter int          NBTN      = 2,
    parameter logic [15:0] COIN_CYC  = 16'd53600,
    parameter int          AF_FRAMES = 2
) (
    input  logic                   i_clk,
    input  logic                   RESETn,
    input  logic [16*NPLAYERS-1:0] joystick,
    input  logic                   vblank,
    input  logic [NBTN-1:0]        af_mask,
    input  logic [1:0]             socd_mode,
    output logic [16*NPLAYERS-1:0] o_player,
    output logic                   o_pause
);
    localparam int J_START = 4 + NBTN;
    localparam int J_COIN  = 5 + NBTN;
    localparam int J_SVC   = 6 + NBTN;
    localparam int J_PAUSE = 7 + NBTN;

    // DIR_A is the L/U side of an axis, DIR_B the R/D side.
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_A    = 2'd1,
        DIR_B    = 2'd2
    } dir_e;

    // Most recent rising edge wins; two edges in one cycle leave the axis undecided.
    function automatic dir_e next_last(input dir_e last, input logic rise_a, input logic rise_b);
        dir_e r;
        r = last;
        if (rise_a && rise_b) begin
            r = DIR_NONE;
        end else if (rise_a) begin
            r = DIR_A;
        end else if (rise_b) begin
            r = DIR_B;
        end
        return r;
    endfunction

    // Returns {b_out, a_out} for one axis.
    function automatic logic [1:0] resolve(input logic [1:0] mode, input logic a, input logic b,
                                           input dir_e last);
        logic [1:0] r;
        r = {b, a};
        if (a && b) begin
            case (mode)
                2'd0:    r = 2'b11;
                2'd2:    r = {last == DIR_B, last == DIR_A};
                default: r = 2'b00;
            endcase
        end
        return r;
    endfunction

    // Stage 1: sampled inputs plus previous-cycle copies for edge detection.
    logic [16*NPLAYERS-1:0] joy_q, joy_prev_q;

    always_ff @(posedge i_clk or negedge RESETn) begin
        if (!RESETn) begin
            joy_q      <= '0;
            joy_prev_q <= '0;
        end else begin
            joy_q      <= joystick;
            joy_prev_q <= joy_q;
        end
    end

    // Not every joystick bit needs an edge detector or a mapping.
    logic unused_joy;
    assign unused_joy = ^{joy_q, joy_prev_q};

    // Conditioned buttons, active-high, player-major.
    logic [NPLAYERS*NBTN-1:0] btn_out;

`ifdef INPUT_AUTOFIRE_EN
    localparam int            FW      = (AF_FRAMES > 1) ? $clog2(AF_FRAMES) : 1;
    localparam logic [FW-1:0] AF_LAST = FW'(AF_FRAMES - 1);

    logic                     vb_q, vb_prev_q, vb_rise, tick;
    logic [FW-1:0]            frame_q, frame_d;
    logic [NPLAYERS*NBTN-1:0] phase_q, phase_d;

    always_ff @(posedge i_clk or negedge RESETn) begin
        if (!RESETn) begin
            vb_q      <= 1'b0;
            vb_prev_q <= 1'b0;
            frame_q   <= '0;
            phase_q   <= '0;
        end else begin
            vb_q      <= vblank;
            vb_prev_q <= vb_q;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
        end
    end

    always_comb begin
        vb_rise = vb_q & ~vb_prev_q;
        tick    = vb_rise && (frame_q == AF_LAST);
        frame_d = frame_q;
        if (vb_rise) begin
            frame_d = tick ? '0 : frame_q + 1'b1;
        end
        phase_d = phase_q;
        btn_out = '0;
        for (int p = 0; p < NPLAYERS; p++) begin
            for (int b = 0; b < NBTN; b++) begin
                // A fresh press always starts on the "fire" phase, so the first shot is immediate.
                if (joy_q[16*p+4+b] && !joy_prev_q[16*p+4+b]) begin
                    phase_d[p*NBTN+b] = 1'b1;
                end else if (tick && joy_q[16*p+4+b]) begin
                    phase_d[p*NBTN+b] = ~phase_q[p*NBTN+b];
                end
                btn_out[p*NBTN+b] = joy_q[16*p+4+b] & (af_mask[b] ? phase_d[p*NBTN+b] : 1'b1);
            end
        end
    end
`else
    always_comb begin
        btn_out = '0;
        for (int p = 0; p < NPLAYERS; p++) begin
            btn_out[p*NBTN +: NBTN] = joy_q[16*p+4 +: NBTN];
        end
    end

    logic unused_af;
    assign unused_af = ^{af_mask, vblank};
`endif

    // Per-player state.
    logic [15:0] coin_cnt_q [NPLAYERS];
    logic [15:0] coin_cnt_d [NPLAYERS];
    dir_e        last_h_q   [NPLAYERS];
    dir_e        last_h_d   [NPLAYERS];
    dir_e        last_v_q   [NPLAYERS];
    dir_e        last_v_d   [NPLAYERS];

    logic [16*NPLAYERS-1:0] player_q, player_d;
    logic                   pause_q, pause_d;

    always_comb begin
        logic [15:0] j, jp, act;
        logic [1:0]  hz, vt;
        logic        pause_now, pause_prev;
        j          = '0;
        jp         = '0;
        act        = '0;
        hz         = '0;
        vt         = '0;
        pause_now  = 1'b0;
        pause_prev = 1'b0;
        player_d   = '1;
        coin_cnt_d = coin_cnt_q;
        last_h_d   = last_h_q;
        last_v_d   = last_v_q;
        for (int p = 0; p < NPLAYERS; p++) begin
            j  = joy_q[16*p +: 16];
            jp = joy_prev_q[16*p +: 16];

            // Reload has priority, so a press landing on the expiry cycle restarts the stretch.
            if (j[J_COIN] && !jp[J_COIN]) begin
                coin_cnt_d[p] = COIN_CYC;
            end else if (coin_cnt_q[p] != 16'd0) begin
                coin_cnt_d[p] = coin_cnt_q[p] - 16'd1;
            end else begin
                coin_cnt_d[p] = 16'd0;
            end

            // Resolve with the updated 'last' so a new press is honoured without an extra cycle.
            last_h_d[p] = next_last(last_h_q[p], j[1] & ~jp[1], j[0] & ~jp[0]);
            last_v_d[p] = next_last(last_v_q[p], j[3] & ~jp[3], j[2] & ~jp[2]);
            hz = resolve(socd_mode, j[1], j[0], last_h_d[p]);   // {R, L}
            vt = resolve(socd_mode, j[3], j[2], last_v_d[p]);   // {D, U}

            act = '0;
            // The previous-cycle coin term gives the held coin one trailing cycle, which lines the
            // held case up with the stretched single-cycle case (COIN_CYC+1 vs N+1).
            act[0]         = j[J_COIN] | jp[J_COIN] | (coin_cnt_q[p] != 16'd0);
            act[1]         = j[J_START];
            act[2 +: NBTN] = btn_out[p*NBTN +: NBTN];
            act[8]         = j[J_SVC];
            act[9]         = hz[0];
            act[10]        = hz[1];
            act[11]        = vt[1];
            act[12]        = vt[0];
            player_d[16*p +: 16] = ~act;

            pause_now  = pause_now | j[J_PAUSE];
            pause_prev = pause_prev | jp[J_PAUSE];
        end
        pause_d = pause_q ^ (pause_now & ~pause_prev);
    end

    // Stage 2: conditioned outputs and per-player state.
    always_ff @(posedge i_clk or negedge RESETn) begin
        if (!RESETn) begin
            player_q <= '1;
            pause_q  <= 1'b0;
            for (int p = 0; p < NPLAYERS; p++) begin
                coin_cnt_q[p] <= 16'd0;
                last_h_q[p]   <= DIR_NONE;
                last_v_q[p]   <= DIR_NONE;
            end
        end else begin
            player_q <= player_d;
            pause_q  <= pause_d;
            for (int p = 0; p < NPLAYERS; p++) begin
                coin_cnt_q[p] <= coin_cnt_d[p];
                last_h_q[p]   <= last_h_d[p];
                last_v_q[p]   <= last_v_d[p];
            end
        end
    end

    assign o_player = player_q;
    assign o_pause  = pause_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
module tb_arcade_input_mapper;
    // Joystick input bits (NBTN = 2).
    localparam logic [15:0] J_R  = 16'h0001;
    localparam logic [15:0] J_L  = 16'h0002;
    localparam logic [15:0] J_D  = 16'h0004;
    localparam logic [15:0] J_U  = 16'h0008;
    localparam logic [15:0] J_B0 = 16'h0010;
    localparam logic [15:0] J_B1 = 16'h0020;
    localparam logic [15:0] J_ST = 16'h0040;
    localparam logic [15:0] J_CN = 16'h0080;
    localparam logic [15:0] J_SV = 16'h0100;
    localparam logic [15:0] J_PZ = 16'h0200;
    // Output bits, written active-high here and inverted by ex().
    localparam logic [15:0] O_CN = 16'h0001;
    localparam logic [15:0] O_ST = 16'h0002;
    localparam logic [15:0] O_B0 = 16'h0004;
    localparam logic [15:0] O_B1 = 16'h0008;
    localparam logic [15:0] O_SV = 16'h0100;
    localparam logic [15:0] O_L  = 16'h0200;
    localparam logic [15:0] O_R  = 16'h0400;
    localparam logic [15:0] O_D  = 16'h0800;
    localparam logic [15:0] O_U  = 16'h1000;
    localparam logic [15:0] Z    = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] joystick;
    logic        vblank;
    logic [1:0]  af_mask;
    logic [1:0]  socd_mode;
    logic [31:0] o_player;
    logic        o_pause;

    arcade_input_mapper #(
        .NPLAYERS (2),
        .NBTN     (2),
        .COIN_CYC (16'd16),
        .AF_FRAMES(1)
    ) dut (
        .i_clk    (clk),
        .RESETn   (rst_n),
        .joystick (joystick),
        .vblank   (vblank),
        .af_mask  (af_mask),
        .socd_mode(socd_mode),
        .o_player (o_player),
        .o_pause  (o_pause)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] pl;
        logic        pz;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   cyc;
    int   total;
    int   bad;
    logic epz;

    function automatic logic [31:0] ex(input logic [15:0] a1, input logic [15:0] a2);
        return {~a2, ~a1};
    endfunction

    // Advance one cycle, then compare every scoreboard entry due now.
    task automatic adv();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        while (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            total++;
            assert ({o_player, o_pause} === {e.pl, e.pz})
            else begin
                bad++;
                $error("FAIL %s cyc=%0d got player=%h pause=%b want player=%h pause=%b",
                       e.tag, cyc, o_player, o_pause, e.pl, e.pz);
            end
        end
    endtask

    // Drive one cycle of input; its conditioned result must appear two edges later.
    task automatic step(input logic [15:0] j1, input logic [15:0] j2, input logic vb,
                        input logic [31:0] epl, input string tag);
        exp_t e;
        joystick = {j2, j1};
        vblank   = vb;
        e.due = cyc + 2;
        e.pl  = epl;
        e.pz  = epz;
        e.tag = tag;
        sbq.push_back(e);
        adv();
    endtask

    initial begin
        logic [15:0] jc;
        logic [15:0] oc;
        logic        vbp [16];
        logic        ph;
        logic        prevvb;

        total = 0;
        bad = 0;
        cyc = 0;
        epz = 1'b0;
        rst_n = 1'b0;
        joystick = '0;
        vblank = 1'b0;
        af_mask = 2'b00;
        socd_mode = 2'd0;
        vbp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        total++;
        assert (o_player === 32'hFFFF_FFFF)
        else begin bad++; $error("FAIL reset_player got=%h want=%h", o_player, 32'hFFFF_FFFF); end
        total++;
        assert (o_pause === 1'b0)
        else begin bad++; $error("FAIL reset_pause got=%b want=0", o_pause); end
        rst_n = 1'b1;

        repeat (3) step(Z, Z, 1'b0, ex(Z, Z), "idle");

        // Single-cycle coin on P1: 17 low cycles.
        for (int i = 0; i < 20; i++) begin
            jc = (i == 0) ? J_CN : Z;
            oc = (i <= 16) ? O_CN : Z;
            step(jc, Z, 1'b0, ex(oc, Z), "coin_1cyc");
        end

        // Mode 0 pass-through, start/service/buttons.
        step(J_SV | J_B0 | J_B1 | J_U | J_D, J_ST | J_L | J_R, 1'b0,
             ex(O_SV | O_B0 | O_B1 | O_U | O_D, O_ST | O_L | O_R), "pass_mode0");
        step(J_ST, J_B1, 1'b0, ex(O_ST, O_B1), "pass_start");
        step(Z, Z, 1'b0, ex(Z, Z), "idle");

        // Mode 1 neutral and mode 3 alias.
        socd_mode = 2'd1;
        step(Z, Z, 1'b0, ex(Z, Z), "idle");
        step(J_L | J_R | J_U | J_D, Z, 1'b0, ex(Z, Z), "neutral_both");
        step(J_L | J_D, Z, 1'b0, ex(O_L | O_D, Z), "neutral_single");
        socd_mode = 2'd3;
        step(Z, J_L | J_R, 1'b0, ex(Z, Z), "mode3_both");
        step(Z, Z, 1'b0, ex(Z, Z), "idle");

        // Mode 2 last-wins.
        socd_mode = 2'd2;
        repeat (5) step(J_L, Z, 1'b0, ex(O_L, Z), "lw_left");
        repeat (3) step(J_L | J_R, Z, 1'b0, ex(O_R, Z), "lw_right_wins");
        repeat (3) step(J_L, Z, 1'b0, ex(O_L, Z), "lw_release_r");
        step(Z, Z, 1'b0, ex(Z, Z), "idle");
        repeat (3) step(J_L | J_R, Z, 1'b0, ex(Z, Z), "lw_simultaneous");
        repeat (2) step(J_R, Z, 1'b0, ex(O_R, Z), "lw_after_simul");
        step(J_L | J_R, Z, 1'b0, ex(O_L, Z), "lw_repress_left");
        step(Z, Z, 1'b0, ex(Z, Z), "idle");
        repeat (2) step(J_U, Z, 1'b0, ex(O_U, Z), "lw_up");
        repeat (2) step(J_U | J_D, Z, 1'b0, ex(O_D, Z), "lw_down_wins");
        step(Z, Z, 1'b0, ex(Z, Z), "idle");
        socd_mode = 2'd0;

        // Buttons held over six vblank pulses, autofire mask on button 0 only.
        af_mask = 2'b01;
        step(Z, Z, 1'b0, ex(Z, Z), "idle");
        ph = 1'b0;
        prevvb = 1'b0;
        for (int i = 0; i < 16; i++) begin
`ifdef INPUT_AUTOFIRE_EN
            if (i == 0) ph = 1'b1;
            else if (vbp[i] && !prevvb) ph = ~ph;
`else
            ph = 1'b1;
`endif
            prevvb = vbp[i];
            oc = ph ? (O_B0 | O_B1) : O_B1;
            step(J_B0 | J_B1, Z, vbp[i], ex(oc, Z), "autofire");
        end
        step(Z, Z, 1'b0, ex(Z, Z), "idle");
        af_mask = 2'b00;

        // Pause toggles: P2, then P1, then both together.
        epz = 1'b1;
        step(Z, J_PZ, 1'b0, ex(Z, Z), "pause_p2");
        repeat (2) step(Z, Z, 1'b0, ex(Z, Z), "pause_hold1");
        epz = 1'b0;
        step(J_PZ, Z, 1'b0, ex(Z, Z), "pause_p1");
        repeat (2) step(Z, Z, 1'b0, ex(Z, Z), "pause_hold0");
        epz = 1'b1;
        repeat (2) step(J_PZ, J_PZ, 1'b0, ex(Z, Z), "pause_both");
        step(Z, Z, 1'b0, ex(Z, Z), "pause_hold1b");

        // Reset during a P2 coin countdown.
        step(Z, J_CN, 1'b0, ex(Z, O_CN), "coin_p2");
        repeat (4) step(Z, Z, 1'b0, ex(Z, O_CN), "coin_p2_stretch");
        rst_n = 1'b0;
        #1;
        total++;
        assert ({o_player, o_pause} === {32'hFFFF_FFFF, 1'b0})
        else begin bad++; $error("FAIL reset_async got player=%h pause=%b want player=ffffffff pause=0", o_player, o_pause); end
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        total++;
        assert ({o_player, o_pause} === {32'hFFFF_FFFF, 1'b0})
        else begin bad++; $error("FAIL reset_hold got player=%h pause=%b want player=ffffffff pause=0", o_player, o_pause); end
        rst_n = 1'b1;
        epz = 1'b0;
        repeat (20) step(Z, Z, 1'b0, ex(Z, Z), "post_reset_idle");
        adv();
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
